ex_stage_alu: RTL and testbench

//  Execute stage directly downstream of the control unit. Consumes ALU_CONTROL/SE2/SE3 plus the register-file operands.

---
 rtl/ex_stage_alu.sv | 163 ++++++++++++++++
 tb/tb_ex_stage_alu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_alu.sv
// Execute stage: ALU + result mux registered into the EX/MEM slot, plus the
// {V,C,N,Z} condition-code register and its interrupt shadow copy.
module ex_stage_alu #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        alu_ctrl,
  input  logic              se2,
  input  logic [1:0]        se3,
  input  logic              upd_flags,
  input  logic [DATA_W-1:0] ra_val,
  input  logic [DATA_W-1:0] rb_val,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_res,
  output logic              ex_zero,
  output logic [3:0]        ccr
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
  localparam logic [DATA_W:0]   ONE_W = (DATA_W+1)'(1);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_RLC = 4'h6, OP_RRC  = 4'h7,
    OP_SETC = 4'h8, OP_CLRC = 4'h9, OP_NOT = 4'hA, OP_NEG = 4'hB,
    OP_INC = 4'hC, OP_DEC = 4'hD
  } alu_op_e;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic [3:0]        ccr_q, ccr_d;
  logic [3:0]        shadow_q, shadow_d;

  logic [DATA_W-1:0] op_a, op_b, alu_r, res_sel;
  logic [DATA_W:0]   sum, diff, inc, dec;
  logic              f_v, f_c;
  logic [3:0]        f_new, f_mask;

  assign op_a = ra_val;
  assign op_b = se2 ? rb_val : ONE_D;
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  assign inc  = {1'b0, op_b} + ONE_W;
  assign dec  = {1'b0, op_b} - ONE_W;

  // f_mask selects which of {V,C,N,Z} the op is allowed to write
  always_comb begin
    alu_r  = op_a;
    f_v    = 1'b0;
    f_c    = 1'b0;
    f_mask = 4'b0000;
    case (alu_op_e'(alu_ctrl))
      OP_NOP:  alu_r = op_a;
      OP_MOV:  alu_r = op_b;
      OP_ADD: begin
        alu_r  = sum[MSB:0];
        f_c    = sum[DATA_W];
        f_v    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
        f_mask = 4'b1111;
      end
      OP_SUB: begin
        alu_r  = diff[MSB:0];
        f_c    = diff[DATA_W];
        f_v    = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
        f_mask = 4'b1111;
      end
      OP_AND: begin alu_r = op_a & op_b; f_mask = 4'b0011; end
      OP_OR:  begin alu_r = op_a | op_b; f_mask = 4'b0011; end
      OP_RLC: begin
        alu_r  = {op_b[MSB-1:0], ccr_q[2]};
        f_c    = op_b[MSB];
        f_mask = 4'b0111;
      end
      OP_RRC: begin
        alu_r  = {ccr_q[2], op_b[MSB:1]};
        f_c    = op_b[0];
        f_mask = 4'b0111;
      end
      OP_SETC: begin f_c = 1'b1; f_mask = 4'b0100; end
      OP_CLRC: begin f_c = 1'b0; f_mask = 4'b0100; end
      OP_NOT:  begin alu_r = ~op_b;      f_mask = 4'b0011; end
      OP_NEG:  begin alu_r = '0 - op_b;  f_mask = 4'b0011; end
      OP_INC: begin
        alu_r  = inc[MSB:0];
        f_c    = inc[DATA_W];
        f_v    = ~op_b[MSB] & inc[MSB];
        f_mask = 4'b1111;
      end
      OP_DEC: begin
        alu_r  = dec[MSB:0];
        f_c    = dec[DATA_W];
        f_v    = op_b[MSB] & ~dec[MSB];
        f_mask = 4'b1111;
      end
      default: alu_r = op_a;
    endcase
  end

  assign f_new = {f_v, f_c, alu_r[MSB], (alu_r == '0)};

  always_comb begin
    case (se3)
      2'd1:    res_sel = ra_val;
      2'd2:    res_sel = rb_val;
      default: res_sel = alu_r;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      res_d   = res_sel;
      zero_d  = (alu_r == '0);
    end
  end

  // Restore wins over everything; save always captures the pre-edge CCR
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (rti_restore)
      ccr_d = shadow_q;
    else if (in_valid && upd_flags && !stall && !flush)
      ccr_d = (ccr_q & ~f_mask) | (f_new & f_mask);
    if (int_save)
      shadow_d = ccr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ccr_q    <= 4'b0000;
      shadow_q <= 4'b0000;
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_res   = res_q;
  assign ex_zero  = zero_q;
  assign ccr      = ccr_q;

endmodule

// File: tb/tb_ex_stage_alu.sv
// Bench for ex_stage_alu: directed scenarios plus a randomized stream checked
// against an integer-arithmetic reference model.
module tb_ex_stage_alu;

  logic       clk, rst;
  logic       in_valid, stall, flush, se2, upd_flags, int_save, rti_restore;
  logic [3:0] alu_ctrl;
  logic [1:0] se3;
  logic [7:0] ra_val, rb_val;
  logic       ex_valid, ex_zero;
  logic [7:0] ex_res;
  logic [3:0] ccr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [3:0] m_ccr, m_sh;
  logic [7:0] m_res;
  logic       m_zero, m_valid;

  ex_stage_alu #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_ctrl(alu_ctrl), .se2(se2), .se3(se3), .upd_flags(upd_flags),
    .ra_val(ra_val), .rb_val(rb_val), .int_save(int_save),
    .rti_restore(rti_restore), .ex_valid(ex_valid), .ex_res(ex_res),
    .ex_zero(ex_zero), .ccr(ccr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  function automatic int to_s(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Spec-level ALU: returns result and the full next CCR (untouched flags kept)
  function automatic void ref_alu(input int op, input int a, input int b,
                                  input logic [3:0] cc, output int r,
                                  output logic [3:0] nc);
    int t;
    logic v, c, n, z;
    bit zn;
    v = cc[3]; c = cc[2]; n = cc[1]; z = cc[0]; zn = 0; r = a;
    case (op)
      0:  r = a;
      1:  r = b;
      2:  begin r = (a + b) % 256; c = (a + b) > 255; t = to_s(a) + to_s(b);
                v = (t > 127) || (t < -128); zn = 1; end
      3:  begin r = (a - b + 256) % 256; c = a < b; t = to_s(a) - to_s(b);
                v = (t > 127) || (t < -128); zn = 1; end
      4:  begin r = a & b; zn = 1; end
      5:  begin r = a | b; zn = 1; end
      6:  begin r = (b * 2 + (c ? 1 : 0)) % 256; c = (b >= 128); zn = 1; end
      7:  begin r = (c ? 128 : 0) + b / 2; c = (b % 2) == 1; zn = 1; end
      8:  c = 1'b1;
      9:  c = 1'b0;
      10: begin r = 255 - b; zn = 1; end
      11: begin r = (256 - b) % 256; zn = 1; end
      12: begin r = (b + 1) % 256; c = (b == 255); v = to_s(b) + 1 > 127; zn = 1; end
      13: begin r = (b + 255) % 256; c = (b == 0); v = to_s(b) - 1 < -128; zn = 1; end
      default: r = a;
    endcase
    if (zn) begin z = (r == 0); n = (r >= 128); end
    nc = {v, c, n, z};
  endfunction

  task automatic model_reset();
    m_ccr = 4'b0; m_sh = 4'b0; m_res = 8'h00; m_zero = 1'b0; m_valid = 1'b0;
  endtask

  // Advance one clock, updating the reference model from the current inputs
  task automatic step();
    int a, b, r, sel;
    logic [3:0] nc, old;
    a = int'(ra_val);
    b = se2 ? int'(rb_val) : 1;
    ref_alu(int'(alu_ctrl), a, b, m_ccr, r, nc);
    sel = (se3 == 2'd1) ? int'(ra_val) : (se3 == 2'd2) ? int'(rb_val) : r;
    @(posedge clk); #1;
    old = m_ccr;
    if (rti_restore) m_ccr = m_sh;
    else if (in_valid && upd_flags && !stall && !flush) m_ccr = nc;
    if (int_save) m_sh = old;
    if (flush) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = in_valid; m_res = 8'(sel); m_zero = (r == 0);
    end
  endtask

  task automatic op_in(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic s2,
                       input logic [1:0] s3, input logic upd);
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0; int_save = 1'b0;
    rti_restore = 1'b0; alu_ctrl = op; ra_val = a; rb_val = b; se2 = s2;
    se3 = s3; upd_flags = upd;
  endtask

  task automatic test_reset();
    op_in(4'h0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_checks++; if (ex_res !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %h want 00", ex_res); end
    n_checks++; if (ex_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", ex_zero); end
    n_checks++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL reset_ccr: got %b want 0000", ccr); end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    op_in(4'h2, 8'h7F, 8'h01, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ex_res !== 8'h80) begin n_fail++; $display("FAIL add_res: got %h want 80", ex_res); end
    n_checks++; if (ccr !== 4'b1010) begin n_fail++; $display("FAIL add_ccr: got %b want 1010", ccr); end
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", ex_valid); end
  endtask

  task automatic test_sub_count();
    for (int i = 0; i < 5; i++) begin
      op_in(4'h3, 8'(5 - i), 8'h77, 1'b0, 2'd0, 1'b0);
      step();
      n_checks++; if (ex_res !== 8'(4 - i)) begin n_fail++; $display("FAIL sub_res[%0d]: got %h want %h", i, ex_res, 8'(4 - i)); end
      n_checks++; if (ex_zero !== (i == 4)) begin n_fail++; $display("FAIL sub_zero[%0d]: got %b want %b", i, ex_zero, (i == 4)); end
      n_checks++; if (ccr !== 4'b1010) begin n_fail++; $display("FAIL sub_ccr[%0d]: got %b want 1010", i, ccr); end
    end
  endtask

  task automatic test_rotate();
    op_in(4'h8, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ccr !== 4'b1110) begin n_fail++; $display("FAIL setc_ccr: got %b want 1110", ccr); end
    op_in(4'h6, 8'h00, 8'h80, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ex_res !== 8'h01) begin n_fail++; $display("FAIL rlc_res: got %h want 01", ex_res); end
    n_checks++; if (ccr !== 4'b1100) begin n_fail++; $display("FAIL rlc_ccr: got %b want 1100", ccr); end
    op_in(4'h7, 8'h00, 8'h01, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ex_res !== 8'h80) begin n_fail++; $display("FAIL rrc_res: got %h want 80", ex_res); end
    n_checks++; if (ccr !== 4'b1110) begin n_fail++; $display("FAIL rrc_ccr: got %b want 1110", ccr); end
  endtask

  task automatic test_stall_flush();
    op_in(4'h2, 8'h10, 8'h20, 1'b1, 2'd0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (ex_res !== 8'h80) begin n_fail++; $display("FAIL stall_res[%0d]: got %h want 80", i, ex_res); end
      n_checks++; if (ccr !== 4'b1110) begin n_fail++; $display("FAIL stall_ccr[%0d]: got %b want 1110", i, ccr); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (ex_res !== 8'h30) begin n_fail++; $display("FAIL unstall_res: got %h want 30", ex_res); end
    n_checks++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL unstall_ccr: got %b want 0000", ccr); end
    op_in(4'h3, 8'h01, 8'h02, 1'b1, 2'd0, 1'b1);
    flush = 1'b1;
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    n_checks++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL flush_ccr: got %b want 0000", ccr); end
    n_checks++; if (ex_res !== 8'h30) begin n_fail++; $display("FAIL flush_res: got %h want 30", ex_res); end
  endtask

  task automatic test_shadow();
    op_in(4'h2, 8'hFF, 8'h01, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ccr !== 4'b0101) begin n_fail++; $display("FAIL sh_setup_ccr: got %b want 0101", ccr); end
    op_in(4'h0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0; int_save = 1'b1;
    step();
    op_in(4'h9, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ccr !== 4'b0001) begin n_fail++; $display("FAIL sh_clrc_ccr: got %b want 0001", ccr); end
    op_in(4'hD, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1);
    step();
    n_checks++; if (ccr !== 4'b0110) begin n_fail++; $display("FAIL sh_dec_ccr: got %b want 0110", ccr); end
    n_checks++; if (ex_res !== 8'hFF) begin n_fail++; $display("FAIL sh_dec_res: got %h want ff", ex_res); end
    op_in(4'h0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0; rti_restore = 1'b1;
    step();
    n_checks++; if (ccr !== 4'b0101) begin n_fail++; $display("FAIL sh_restore_ccr: got %b want 0101", ccr); end
    op_in(4'h9, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1);
    step();
    op_in(4'h0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0; int_save = 1'b1; rti_restore = 1'b1;
    step();
    n_checks++; if (ccr !== 4'b0101) begin n_fail++; $display("FAIL swap_ccr: got %b want 0101", ccr); end
    int_save = 1'b0;
    step();
    n_checks++; if (ccr !== 4'b0001) begin n_fail++; $display("FAIL swap_shadow: got %b want 0001", ccr); end
  endtask

  task automatic test_se3_mux();
    op_in(4'h1, 8'h00, 8'hA5, 1'b1, 2'd2, 1'b1);
    step();
    n_checks++; if (ex_res !== 8'hA5) begin n_fail++; $display("FAIL mov_res: got %h want a5", ex_res); end
    n_checks++; if (ccr !== 4'b0001) begin n_fail++; $display("FAIL mov_ccr: got %b want 0001", ccr); end
    op_in(4'hE, 8'h3C, 8'h00, 1'b0, 2'd1, 1'b0);
    step();
    n_checks++; if (ex_res !== 8'h3C) begin n_fail++; $display("FAIL push_res: got %h want 3c", ex_res); end
    n_checks++; if (ccr !== 4'b0001) begin n_fail++; $display("FAIL push_ccr: got %b want 0001", ccr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      op_in(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 4) != 0));
      in_valid    = ($urandom_range(0, 4) != 0);
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      int_save    = ($urandom_range(0, 9) == 0);
      rti_restore = ($urandom_range(0, 9) == 0);
      if (i == 300) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if ({ex_valid, ex_res, ex_zero, ccr} !== 14'd0) begin n_fail++; $display("FAIL midrst_outputs: got %b want all 0", {ex_valid, ex_res, ex_zero, ccr}); end
        @(posedge clk); #1;
        rst = 1'b0;
      end
      step();
      n_checks++; if (ex_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, ex_valid, m_valid); end
      n_checks++; if (ex_res !== m_res) begin n_fail++; $display("FAIL rnd_res[%0d]: got %h want %h", i, ex_res, m_res); end
      n_checks++; if (ex_zero !== m_zero) begin n_fail++; $display("FAIL rnd_zero[%0d]: got %b want %b", i, ex_zero, m_zero); end
      n_checks++; if (ccr !== m_ccr) begin n_fail++; $display("FAIL rnd_ccr[%0d]: got %b want %b", i, ccr, m_ccr); end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_count();
    test_rotate();
    test_stall_flush();
    test_shadow();
    test_se3_mux();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
